fetch_queue_unit: RTL and testbench

Parametrised instruction fetch stage with a prefetch queue. Generates sequential PCs, drives a synchronous instruction memory (1-cycle read latency), and buffers returned instructions with their PCs in a DEPTH-entry FIFO. Decode drains it through a valid/ready handshake. Supports taken-branch redirect with signed-magnitude offset (queue flush plus in-flight kill), halt/resume, and back-pressure.

---
 rtl/fetch_queue_unit.sv | 94 +++++++++
 tb/tb_fetch_queue_unit.sv | 133 +++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: sequential PC generation, 1-cycle synchronous imem,
// and a DEPTH-entry prefetch queue drained by decode through valid/ready.
module fetch_queue_unit #(
  parameter int PC_W = 16,
  parameter int INSTR_W = 9,
  parameter int DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  localparam int CNT_W = $clog2(DEPTH+1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_base,
  input  logic [PC_W-1:0]    redirect_offset,
  input  logic               redirect_sign,
  input  logic               halt_req,
  input  logic               resume,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic               halted,
  output logic [CNT_W-1:0]   count
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } entry_t;

  entry_t            q [DEPTH];
  logic [PC_W-1:0]   fetch_pc, inflight_pc, target;
  logic              halted_q, inflight;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W:0]    reserved;
  logic              deq, enq;

  assign deq = (cnt != '0) & out_ready;
  assign enq = inflight & ~redirect_valid;

  // Slots already claimed after this cycle: occupancy minus the leaving head
  // plus the response still in flight. A new request only goes out if it fits.
  assign reserved = {1'b0, cnt} - {{CNT_W{1'b0}}, deq} + {{CNT_W{1'b0}}, inflight};
  assign imem_req = ~reset & ~halted_q & ~redirect_valid & (reserved < (CNT_W+1)'(DEPTH));
  assign imem_addr = fetch_pc;
  assign target = redirect_sign ? redirect_base + redirect_offset
                                : redirect_base - redirect_offset;

  assign out_valid = (cnt != '0);
  assign out_instr = out_valid ? q[rd_ptr].instr : '0;
  assign out_pc    = out_valid ? q[rd_ptr].pc : '0;
  assign halted    = halted_q;
  assign count     = cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      halted_q    <= 1'b0;
      inflight    <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      cnt         <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      halted_q <= halt_req | (halted_q & ~resume);
      inflight <= imem_req;
      if (imem_req) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + PC_W'(1);
      end
      // Redirect flushes the queue and drops the in-flight response; imem_req
      // is already suppressed this cycle, so the target is fetched next cycle.
      if (redirect_valid) begin
        fetch_pc <= target;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        cnt      <= '0;
      end else begin
        if (enq) begin
          q[wr_ptr] <= {imem_data, inflight_pc};
          wr_ptr    <= wr_ptr + PTR_W'(1);
        end
        if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
        cnt <= cnt + CNT_W'(enq) - CNT_W'(deq);
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Randomized + directed bench for fetch_queue_unit against a queue-based reference model.
module tb_fetch_queue_unit;
  localparam int PC_W = 16, INSTR_W = 9, DEPTH = 4, CNT_W = $clog2(DEPTH+1);
  localparam logic [PC_W-1:0] RESET_PC = '0;

  logic clk = 0, reset = 1;
  logic redirect_valid = 0, redirect_sign = 0, halt_req = 0, resume = 0, out_ready = 0;
  logic [PC_W-1:0] redirect_base = '0, redirect_offset = '0;
  logic imem_req, out_valid, halted;
  logic [PC_W-1:0] imem_addr, out_pc;
  logic [INSTR_W-1:0] imem_data = '0, out_instr;
  logic [CNT_W-1:0] count;

  fetch_queue_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_base(redirect_base),
    .redirect_offset(redirect_offset), .redirect_sign(redirect_sign), .halt_req(halt_req),
    .resume(resume), .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .halted(halted), .count(count));

  always #5 clk = ~clk;

  // Synchronous instruction memory: content is the low bits of the address.
  always @(posedge clk) if (imem_req) imem_data <= imem_addr[INSTR_W-1:0];

  typedef struct { logic [INSTR_W-1:0] instr; logic [PC_W-1:0] pc; } ent_t;
  ent_t mq[$];
  logic [PC_W-1:0] m_fpc, m_pend_pc;
  logic m_halted, m_pend;
  int n_cmp = 0, n_err = 0, cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete(); m_fpc = RESET_PC; m_halted = 0; m_pend = 0; m_pend_pc = '0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic rst, rdy, rv, rs, hr, rsm,
                      input logic [PC_W-1:0] rb = '0, input logic [PC_W-1:0] ro = '0);
    bit e_deq, e_req;
    logic [PC_W-1:0] tgt;
    ent_t e;
    @(negedge clk);
    reset = rst; out_ready = rdy; redirect_valid = rv; redirect_sign = rs;
    halt_req = hr; resume = rsm; redirect_base = rb; redirect_offset = ro;
    #1;
    e_deq = (mq.size() != 0) && rdy;
    e_req = !rst && !m_halted && !rv && (mq.size() - int'(e_deq) + int'(m_pend) < DEPTH);
    chk("imem_req", imem_req, e_req);
    chk("imem_addr", imem_addr, m_fpc);
    chk("out_valid", out_valid, mq.size() != 0);
    chk("out_pc", out_pc, mq.size() != 0 ? mq[0].pc : '0);
    chk("out_instr", out_instr, mq.size() != 0 ? mq[0].instr : '0);
    chk("halted", halted, m_halted);
    chk("count", count, mq.size());
    cyc++;
    if (rst) model_reset();
    else begin
      if (e_deq) void'(mq.pop_front());
      if (rv) begin
        mq.delete();
        tgt = rs ? rb + ro : rb - ro;
      end else if (m_pend) begin
        e.instr = m_pend_pc[INSTR_W-1:0]; e.pc = m_pend_pc;
        mq.push_back(e);
      end
      m_pend = e_req;
      if (e_req) begin m_pend_pc = m_fpc; m_fpc = m_fpc + 1'b1; end
      if (rv) m_fpc = tgt;
      m_halted = hr ? 1'b1 : (rsm ? 1'b0 : m_halted);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    model_reset();
    repeat (2) step(1, 0, 0, 0, 0, 0);
    // Streaming with decode always ready
    repeat (12) step(0, 1, 0, 0, 0, 0);
    // Back-pressure saturation
    repeat (10) step(0, 0, 0, 0, 0, 0);
    chk("sat_count", count, DEPTH);
    chk("sat_req", imem_req, 0);
    repeat (8) step(0, 1, 0, 0, 0, 0);
    // Redirect: 0x0010 - 5 = 0x000B
    repeat (3) step(0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 16'h0010, 16'h0005);
    step(0, 1, 0, 0, 0, 0);
    chk("redir_flush", out_valid, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("redir_tgt_valid", out_valid, 1);
    chk("redir_tgt_pc", out_pc, 16'h000B);
    // Redirect: 0xFFFE + 3 wraps to 0x0001
    step(0, 1, 1, 1, 0, 0, 16'hFFFE, 16'h0003);
    repeat (3) step(0, 1, 0, 0, 0, 0);
    chk("wrap_tgt_pc", out_pc, 16'h0001);
    // Halt pulse, drain, resume
    step(0, 1, 0, 0, 1, 0);
    repeat (8) step(0, 1, 0, 0, 0, 0);
    chk("halt_state", halted, 1);
    chk("halt_drained", count, 0);
    step(0, 1, 0, 0, 0, 1);
    repeat (5) step(0, 1, 0, 0, 0, 0);
    // Halt with resume in the same cycle: halt wins
    step(0, 1, 0, 0, 1, 1);
    step(0, 1, 0, 0, 0, 0);
    chk("halt_wins", halted, 1);
    step(0, 1, 0, 0, 0, 1);
    // Mid-stream reset with entries queued
    repeat (5) step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("rst_count", count, 0);
    chk("rst_addr", imem_addr, RESET_PC);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) == 0), $urandom_range(0, 1),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
           PC_W'($urandom), PC_W'($urandom_range(0, 300)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
